watch_window_memory: RTL and testbench
======================================

Name: watch_window_memory

Overview:
- Parametrised successor to the single-last-word mirrored RAM.
- Byte-strobed word memory with a registered read port, a self-clearing initialisation sequencer, and a configurable window of pWatchWords consecutive words. The window is mirrored to flat outputs and carries per-word sticky dirty flags and an interrupt.
- Sits between the core's load/store path and host/testbench observers, for example a result mailbox or a tohost-style signalling area.

Parameters:
pWords, 128, memory depth in 32-bit words (2..65536)
pWatchWords, 4, number of mirrored words in the watch window (1..pWords)
pWatchBase, pWords-pWatchWords, word index of the first watched word; pWatchBase+pWatchWords <= pWords

Ports:
iwClk  in  1  clock, all logic on rising edge
iwRst  in  1  synchronous active-high reset
iwReadEn  in  1  read request
iwReadAddr  in  32  byte address of read; word index = addr[31:2]
owReadData  out  32  read data, registered
owReadValid  out  1  high one cycle after an accepted read
iwWriteAddr  in  32  byte address of write; word index = addr[31:2]
iwWriteData  in  32  write data
iwWstrb  in  4  byte strobes; bit n enables byte n; 0 = no write
owBusy  out  1  initialisation clear in progress; requests ignored
owWatchData  out  32*pWatchWords  mirrored window; word k at bits [32k+31:32k]
owWatchDirty  out  pWatchWords  sticky per-word written flag
iwDirtyClr  in  pWatchWords  per-word dirty clear, level-sampled
owWatchIrq  out  1  OR of owWatchDirty, registered

Behaviour:
- Reset (iwRst=1 at an edge):
  - State goes to CLEAR and the clear counter to 0.
  - owReadData=0, owReadValid=0, owWatchData=0, owWatchDirty=0, owWatchIrq=0, owBusy=1.
  - Held reset keeps counter at 0.
  - Reset during CLEAR or IDLE restarts the clear.
- FSM with two states:
  - CLEAR: each cycle after reset release, write 0 to word[counter], then counter+1. After word pWords-1 is written, go to IDLE. owBusy falls on the same edge.
  - owBusy is high for exactly pWords cycles after the last reset cycle.
  - IDLE: normal operation. No exit except reset.
- During CLEAR:
  - iwReadEn and iwWstrb are ignored; owReadValid stays 0.
  - iwDirtyClr still applies; dirty flags are already 0.
- Write (IDLE, iwWstrb!=0):
  - Each strobed byte is updated at the edge. Unstrobed bytes keep their value.
  - Word index >= pWords: write dropped, no side effects.
  - If the index is in [pWatchBase, pWatchBase+pWatchWords), the matching owWatchData word updates its strobed bytes on the same edge. It is visible the cycle after the write.
  - The matching dirty bit is set, even when the written value is unchanged.
- Dirty/IRQ:
  - iwDirtyClr[k]=1 clears bit k at the edge.
  - A simultaneous set and clear of the same bit leaves it SET.
  - owWatchIrq = registered OR of the next-state dirty vector, so it rises on the same edge as the flag.
- Read (IDLE, iwReadEn=1):
  - Latency 1: owReadData and owReadValid are registered.
  - owReadValid=1 for exactly one cycle per accepted request. Back-to-back reads give one result per cycle.
  - Word index >= pWords returns 0 with owReadValid=1.
  - Read and write to the same word in one cycle: read returns the OLD data.
  - With iwReadEn=0, owReadData holds its last value.
- Address bits [1:0] are ignored for both ports.
- Watch mirror invariant: owWatchData always equals memory contents at the window addresses, including zeros after CLEAR.
- No X propagation: all memory words are defined after CLEAR completes.

Test Plan:
1. Init clear:
   - Stimulus: pulse iwRst 3 cycles, release. Count owBusy.
   - Required: owBusy high exactly 128 cycles.
   - Stimulus: after busy falls, read word 0, word 64, word 127.
   - Required: owReadValid=1 and data 0 for each, each one cycle after its request.
2. Strobed write/read:
   - Stimulus: write 0xDEADBEEF strb 0xF to addr 0x10, then 0x00000055 strb 0x1 to 0x10, then read 0x10.
   - Required: 0xDEADBE55 with latency 1.
   - Stimulus: read addr 0x400 (index 256, out of range).
   - Required: owReadValid=1, data 0.
3. Watch window:
   - Stimulus: write 0x12345678 strb 0xC to word 125 (byte addr 0x1F4; 125 = pWatchBase+1 with pWords=128, pWatchWords=4).
   - Required: next cycle owWatchData[63:32]=0x12340000, owWatchDirty=4'b0010, owWatchIrq=1.
   - Stimulus: write to word 123 (outside window).
   - Required: no watch, dirty or IRQ change.
4. Dirty collision:
   - Stimulus: assert iwDirtyClr=4'b0010 in the same cycle as another write to word 125.
   - Required: bit 1 stays 1.
   - Stimulus: next cycle, clear alone.
   - Required: owWatchDirty=0, owWatchIrq=0 one cycle later.
5. Read-during-write:
   - Stimulus: word 5 holds 0xAAAAAAAA; read and write 0xBBBBBBBB to word 5 in the same cycle.
   - Required: owReadData=0xAAAAAAAA.
   - Stimulus: next read of word 5.
   - Required: 0xBBBBBBBB.
6. Reset mid-clear and mid-operation:
   - Stimulus: assert iwRst at clear cycle 40, then release.
   - Required: owBusy high 128 further cycles.
   - Stimulus: reset after watch word 127 was written 0xFFFFFFFF.
   - Required: owWatchData=0 and dirty=0 immediately. A read of word 127 after CLEAR returns 0.

Source files
------------

// File: rtl/watch_window_memory.sv
// watch_window_memory: byte-strobed word RAM with self-clearing init and a mirrored, dirty-tracked watch window
module watch_window_memory #(
  parameter int pWords      = 128,
  parameter int pWatchWords = 4,
  parameter int pWatchBase  = pWords - pWatchWords
) (
  input  logic                      iwClk,
  input  logic                      iwRst,
  input  logic                      iwReadEn,
  input  logic [31:0]               iwReadAddr,
  output logic [31:0]               owReadData,
  output logic                      owReadValid,
  input  logic [31:0]               iwWriteAddr,
  input  logic [31:0]               iwWriteData,
  input  logic [3:0]                iwWstrb,
  output logic                      owBusy,
  output logic [32*pWatchWords-1:0] owWatchData,
  output logic [pWatchWords-1:0]    owWatchDirty,
  input  logic [pWatchWords-1:0]    iwDirtyClr,
  output logic                      owWatchIrq
);
  localparam int AW = (pWords > 1) ? $clog2(pWords) : 1;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t r_state, w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [31:0] r_mem [pWords];
  logic [31:0] r_watch [pWatchWords];
  logic [31:0] r_rdata;
  logic r_rvalid;
  logic [pWatchWords-1:0] r_dirty, w_dirty_nxt, w_dset;
  logic r_irq;
  logic [29:0] w_widx, w_ridx;
  logic w_win, w_rin, w_we, w_re, w_last;
  logic w_unused;
  assign w_unused = ^{iwReadAddr[1:0], iwWriteAddr[1:0]};
  assign w_widx = iwWriteAddr[31:2];
  assign w_ridx = iwReadAddr[31:2];
  assign w_win = {2'b00, w_widx} < 32'(pWords);
  assign w_rin = {2'b00, w_ridx} < 32'(pWords);
  assign w_we = (r_state == IDLE) && (|iwWstrb) && w_win;
  assign w_re = (r_state == IDLE) && iwReadEn;
  assign w_last = r_cnt == AW'(pWords - 1);
  assign owBusy = r_state == CLEAR;
  assign owReadData = r_rdata;
  assign owReadValid = r_rvalid;
  assign owWatchDirty = r_dirty;
  assign owWatchIrq = r_irq;
  // state register and clear counter
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      r_state <= CLEAR;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= (r_state == CLEAR) ? r_cnt + AW'(1) : r_cnt;
    end
  end
  // leave CLEAR once the last word has been zeroed
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == CLEAR && w_last) w_state_nxt = IDLE;
  end
  // storage: zero fill while clearing, strobed byte writes afterwards
  always_ff @(posedge iwClk) begin
    if (!iwRst && r_state == CLEAR) r_mem[r_cnt] <= '0;
    else if (!iwRst && w_we)
      for (int b = 0; b < 4; b++)
        if (iwWstrb[b]) r_mem[w_widx[AW-1:0]][8*b+:8] <= iwWriteData[8*b+:8];
  end
  // registered read port; out-of-range reads return zero, data holds when idle
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      r_rdata <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_re;
      if (w_re) r_rdata <= w_rin ? r_mem[w_ridx[AW-1:0]] : '0;
    end
  end
  for (genvar k = 0; k < pWatchWords; k++) begin : g_watch
    assign w_dset[k] = w_we && (w_widx == 30'(pWatchBase + k));
    assign owWatchData[32*k+:32] = r_watch[k];
    // mirror of one watched word, tracking the same strobed writes as the RAM
    always_ff @(posedge iwClk) begin
      if (iwRst) r_watch[k] <= '0;
      else if (w_dset[k])
        for (int b = 0; b < 4; b++)
          if (iwWstrb[b]) r_watch[k][8*b+:8] <= iwWriteData[8*b+:8];
    end
  end
  assign w_dirty_nxt = (r_dirty & ~iwDirtyClr) | w_dset;
  // sticky dirty flags with set winning over clear; irq tracks the next-state OR
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      r_dirty <= '0;
      r_irq <= 1'b0;
    end else begin
      r_dirty <= w_dirty_nxt;
      r_irq <= |w_dirty_nxt;
    end
  end
endmodule

// File: tb/tb_watch_window_memory.sv
// tb_watch_window_memory: directed self-checking bench for watch_window_memory
module tb_watch_window_memory;
  logic iwClk = 0, iwRst = 1, iwReadEn = 0;
  logic [31:0] iwReadAddr = 0, iwWriteAddr = 0, iwWriteData = 0;
  logic [3:0] iwWstrb = 0, iwDirtyClr = 0;
  logic [31:0] owReadData;
  logic owReadValid, owBusy, owWatchIrq;
  logic [127:0] owWatchData;
  logic [3:0] owWatchDirty;
  int total = 0, bad = 0, n;
  watch_window_memory dut (
    .iwClk(iwClk), .iwRst(iwRst), .iwReadEn(iwReadEn), .iwReadAddr(iwReadAddr),
    .owReadData(owReadData), .owReadValid(owReadValid), .iwWriteAddr(iwWriteAddr),
    .iwWriteData(iwWriteData), .iwWstrb(iwWstrb), .owBusy(owBusy),
    .owWatchData(owWatchData), .owWatchDirty(owWatchDirty), .iwDirtyClr(iwDirtyClr),
    .owWatchIrq(owWatchIrq)
  );
  always #5 iwClk = ~iwClk;
  task automatic step();
    @(posedge iwClk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic count_busy();
    n = 0;
    while (owBusy && n < 300) begin
      n++;
      step();
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    iwWriteAddr = a; iwWriteData = d; iwWstrb = s;
    step();
    iwWstrb = 0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    iwReadEn = 1; iwReadAddr = a;
    step();
    iwReadEn = 0;
    chk({tag, "_valid"}, 128'(owReadValid), 128'(1));
    chk({tag, "_data"}, 128'(owReadData), 128'(exp));
  endtask
  initial begin
    repeat (3) step();
    chk("rst_busy", 128'(owBusy), 128'(1));
    chk("rst_rvalid", 128'(owReadValid), 128'(0));
    chk("rst_rdata", 128'(owReadData), 128'(0));
    chk("rst_watch", owWatchData, 128'(0));
    chk("rst_dirty", 128'(owWatchDirty), 128'(0));
    chk("rst_irq", 128'(owWatchIrq), 128'(0));
    iwRst = 0;
    count_busy();
    chk("init_busy_cycles", 128'(n), 128'(128));
    rd("rd_w0", 32'h0, 32'h0);
    rd("rd_w64", 32'h100, 32'h0);
    rd("rd_w127", 32'h1FC, 32'h0);
    step();
    chk("rvalid_drop", 128'(owReadValid), 128'(0));
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    wr(32'h10, 32'h00000055, 4'h1);
    rd("rd_strb", 32'h10, 32'hDEADBE55);
    rd("rd_oor", 32'h400, 32'h0);
    wr(32'h1F4, 32'h12345678, 4'hC);
    chk("win_data", owWatchData, {64'h0, 32'h12340000, 32'h0});
    chk("win_dirty", 128'(owWatchDirty), 128'(4'b0010));
    chk("win_irq", 128'(owWatchIrq), 128'(1));
    wr(32'h1EC, 32'hFFFFFFFF, 4'hF);
    chk("outside_data", owWatchData, {64'h0, 32'h12340000, 32'h0});
    chk("outside_dirty", 128'(owWatchDirty), 128'(4'b0010));
    iwDirtyClr = 4'b0010;
    wr(32'h1F4, 32'hAABBCCDD, 4'h1);
    chk("coll_dirty", 128'(owWatchDirty), 128'(4'b0010));
    chk("coll_data", owWatchData, {64'h0, 32'h123400DD, 32'h0});
    step();
    iwDirtyClr = 0;
    chk("clr_dirty", 128'(owWatchDirty), 128'(0));
    chk("clr_irq", 128'(owWatchIrq), 128'(0));
    wr(32'h14, 32'hAAAAAAAA, 4'hF);
    iwReadEn = 1; iwReadAddr = 32'h14;
    wr(32'h14, 32'hBBBBBBBB, 4'hF);
    chk("rdw_old", 128'(owReadData), 128'(32'hAAAAAAAA));
    step();
    iwReadEn = 0;
    chk("rdw_new", 128'(owReadData), 128'(32'hBBBBBBBB));
    step();
    chk("hold_data", 128'(owReadData), 128'(32'hBBBBBBBB));
    chk("hold_valid", 128'(owReadValid), 128'(0));
    rd("rd_lowbits", 32'h17, 32'hBBBBBBBB);
    iwRst = 1;
    step();
    iwRst = 0;
    iwReadEn = 1; iwReadAddr = 32'h14;
    iwWriteAddr = 32'h1FC; iwWriteData = 32'hFFFFFFFF; iwWstrb = 4'hF;
    repeat (40) step();
    chk("clear_rvalid", 128'(owReadValid), 128'(0));
    chk("clear_dirty", 128'(owWatchDirty), 128'(0));
    chk("clear_watch", owWatchData, 128'(0));
    iwReadEn = 0; iwWstrb = 0;
    iwRst = 1;
    step();
    iwRst = 0;
    count_busy();
    chk("midclear_busy_cycles", 128'(n), 128'(128));
    rd("rd_w5_cleared", 32'h14, 32'h0);
    wr(32'h1FC, 32'hFFFFFFFF, 4'hF);
    chk("w127_data", owWatchData, {32'hFFFFFFFF, 96'h0});
    chk("w127_dirty", 128'(owWatchDirty), 128'(4'b1000));
    iwRst = 1;
    step();
    chk("rst2_watch", owWatchData, 128'(0));
    chk("rst2_dirty", 128'(owWatchDirty), 128'(0));
    chk("rst2_irq", 128'(owWatchIrq), 128'(0));
    iwRst = 0;
    count_busy();
    chk("rst2_busy_cycles", 128'(n), 128'(128));
    rd("rd_w127_after", 32'h1FC, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
